// File: rtl/timer_ctrl.sv
// Run-control FSM for an external 4-bit synchronous counter.
// Handles one-shot and auto-reload timing, stop, irq/overrun/error flags.
module timer_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       mode,
  input  logic       ack,
  input  logic [3:0] cnt_in,
  input  logic       tc_in,
  output logic       cten,
  output logic       cnt_clr,
  output logic       busy,
  output logic       done,
  output logic       irq,
  output logic       ovr,
  output logic       err,
  output logic [3:0] target
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, EXPIRE} state_t;

  state_t state;
  logic   match;

  assign match = (cnt_in == target);

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      target <= 4'hF;
      irq    <= 1'b0;
      ovr    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // load and start in the same cycle: the new value governs this run
          if (load) target <= load_val;
          if (start && !stop) state <= CLEAR;
        end
        CLEAR:   state <= stop ? IDLE : RUN;
        RUN: begin
          if (stop)       state <= IDLE;
          else if (match) state <= EXPIRE;
        end
        EXPIRE:  state <= (stop || !mode) ? IDLE : CLEAR;
        default: state <= IDLE;
      endcase

      if (state == RUN && tc_in) err <= 1'b1;

      // Expiry wins over ack; a repeat expiry without ack is an overrun
      if (state == EXPIRE) begin
        irq <= 1'b1;
        if (irq && !ack) ovr <= 1'b1;
      end else if (ack) begin
        irq <= 1'b0;
      end
    end
  end

  assign cten    = (state == RUN) && !match;
  assign cnt_clr = (state == CLEAR);
  assign busy    = (state != IDLE);
  assign done    = (state == EXPIRE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural 4-bit counter and a
// scoreboard of expected done cycles.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic       mode = 1'b0, ack = 1'b0, tc_force = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] cnt = 4'd0;
  logic       tc_in;
  logic       cten, cnt_clr, busy, done, irq, ovr, err;
  logic [3:0] target;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  timer_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .mode(mode), .ack(ack), .cnt_in(cnt), .tc_in(tc_in),
    .cten(cten), .cnt_clr(cnt_clr), .busy(busy), .done(done), .irq(irq),
    .ovr(ovr), .err(err), .target(target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter model
  always @(posedge clk) begin
    if (clr || cnt_clr) cnt <= 4'd0;
    else if (cten)      cnt <= cnt + 4'd1;
  end
  assign tc_in = (cnt == 4'hF) | tc_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each done pulse must match the oldest expected expiry cycle
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) chk("done_unexpected", cyc, 32'hFFFF_FFFF);
      else                   chk("done_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic load_tgt(input logic [3:0] v);
    load_val = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic kick(input logic m, input int t, input bit expect_done, output int n);
    n = cyc;
    start = 1'b1;
    mode = m;
    if (expect_done) exp_q.push_back(n + t + 3);
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, s;
    // Reset state
    tick(2);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_target", target, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_cten", cten, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_err", err, 0);

    // One-shot, target 5
    load_tgt(4'd5);
    @(negedge clk);
    chk("load_target", target, 5);
    kick(1'b0, 5, 1'b1, n);
    @(negedge clk);
    chk("clear_cnt_clr", cnt_clr, 1);
    chk("clear_cten", cten, 0);
    chk("clear_busy", busy, 1);
    s = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s += int'(cten);
      chk("run_excl", cten & cnt_clr, 0);
    end
    chk("run_cten_cycles", s, 5);
    @(negedge clk);
    @(negedge clk);
    chk("os_busy_after", busy, 0);
    chk("os_irq", irq, 1);
    chk("os_ovr", ovr, 0);

    // Auto-reload, target 3, overrun on second expiry
    ack = 1'b1; tick(1); ack = 1'b0;
    @(negedge clk);
    chk("ack_clears_irq", irq, 0);
    load_tgt(4'd3);
    kick(1'b1, 3, 1'b1, n);
    exp_q.push_back(n + 12);
    run_to(n + 7);
    @(negedge clk);
    chk("ar_irq_first", irq, 1);
    chk("ar_ovr_first", ovr, 0);
    run_to(n + 13);
    stop = 1'b1; tick(1); stop = 1'b0;
    @(negedge clk);
    chk("ar_stop_busy", busy, 0);
    chk("ar_ovr_set", ovr, 1);
    ack = 1'b1; tick(1); ack = 1'b0;
    @(negedge clk);
    chk("ar_ack_irq", irq, 0);
    chk("ar_ovr_sticky", ovr, 1);

    // Target 0: single RUN cycle with cten low
    load_tgt(4'd0);
    kick(1'b0, 0, 1'b1, n);
    run_to(n + 2);
    @(negedge clk);
    chk("t0_run_busy", busy, 1);
    chk("t0_run_cten", cten, 0);
    run_to(n + 4);
    @(negedge clk);
    chk("t0_idle", busy, 0);
    chk("t0_irq", irq, 1);

    // Target 9 aborted by stop at count 4; start/load ignored mid-run
    load_tgt(4'd9);
    kick(1'b0, 9, 1'b0, n);
    run_to(n + 3);
    start = 1'b1; load = 1'b1; load_val = 4'd2;
    tick(1);
    start = 1'b0; load = 1'b0;
    for (int i = 0; i < 20 && cnt != 4'd4; i++) tick(1);
    chk("stop_cnt_reached", cnt, 4);
    stop = 1'b1; tick(1); stop = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_cten", cten, 0);
    chk("stop_target_kept", target, 9);
    chk("stop_irq_kept", irq, 1);
    tick(12);

    // tc_in during RUN sets err without disturbing the run
    load_tgt(4'd6);
    kick(1'b0, 6, 1'b1, n);
    run_to(n + 4);
    tc_force = 1'b1; tick(1); tc_force = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_busy", busy, 1);
    run_to(n + 10);
    @(negedge clk);
    chk("err_run_done_idle", busy, 0);
    chk("err_sticky", err, 1);

    // clr mid-run abandons the run
    load_tgt(4'd7);
    kick(1'b0, 7, 1'b0, n);
    run_to(n + 4);
    clr = 1'b1; tick(1);
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_cten", cten, 0);
    chk("clr_cnt_clr", cnt_clr, 0);
    chk("clr_done", done, 0);
    chk("clr_irq", irq, 0);
    chk("clr_ovr", ovr, 0);
    chk("clr_err", err, 0);
    chk("clr_target", target, 4'hF);
    clr = 1'b0;
    tick(1);

    // ack coinciding with expiry: irq stays set, no overrun
    load_tgt(4'd1);
    kick(1'b0, 1, 1'b1, n);
    run_to(n + 5);
    kick(1'b0, 1, 1'b1, n);
    run_to(n + 4);
    ack = 1'b1; tick(1); ack = 1'b0;
    @(negedge clk);
    chk("ack_exp_irq", irq, 1);
    chk("ack_exp_ovr", ovr, 0);

    // stop in EXPIRE beats auto-reload but keeps done and irq
    ack = 1'b1; tick(1); ack = 1'b0;
    load_tgt(4'd2);
    kick(1'b1, 2, 1'b1, n);
    run_to(n + 5);
    stop = 1'b1; tick(1); stop = 1'b0;
    @(negedge clk);
    chk("stop_exp_busy", busy, 0);
    chk("stop_exp_irq", irq, 1);
    mode = 1'b0;
    tick(8);

    chk("done_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
